// File: rtl/rst_seq.sv
// Multi-domain reset sequencer: releases per-domain resets one at a time in
// ascending order with a fixed cycle gap, and supports a warm-reset req/ack
// handshake that re-runs the full sequence without a top-level reset.
module rst_seq #(
    parameter int unsigned NUM_DOMAINS      = 3,
    parameter int unsigned GAP_CYCLES       = 4,
    parameter int unsigned WARM_HOLD_CYCLES = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               warm_req_i,
    output logic                               warm_ack_o,
    output logic [NUM_DOMAINS-1:0]             rst_dom_o,
    output logic [$clog2(NUM_DOMAINS+1)-1:0]   stage_o,
    output logic                               seq_done_o
);

    localparam int unsigned SW      = $clog2(NUM_DOMAINS + 1);
    localparam int unsigned CNT_MAX = (GAP_CYCLES > WARM_HOLD_CYCLES) ? GAP_CYCLES
                                                                      : WARM_HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [NUM_DOMAINS-1:0] ALL_ONES   = '1;
    localparam logic [CW-1:0]          GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]          WARM_LAST  = CW'(WARM_HOLD_CYCLES - 1);
    localparam logic [SW-1:0]          LAST_STAGE = SW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        DONE = 2'd1,
        WARM = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          warm;

    // Sequencer FSM; every output is a register so the reset tree sees clean edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= SEQ;
            cnt        <= '0;
            warm       <= 1'b0;
            rst_dom_o  <= ALL_ONES;
            stage_o    <= '0;
            seq_done_o <= 1'b0;
            warm_ack_o <= 1'b0;
        end else begin
            warm_ack_o <= 1'b0;
            case (state)
                SEQ: begin
                    if (cnt == GAP_LAST) begin
                        // Releasing the next domain keeps the mask contiguous from stage up.
                        cnt       <= '0;
                        stage_o   <= stage_o + SW'(1);
                        rst_dom_o <= ALL_ONES << (stage_o + SW'(1));
                        if (stage_o == LAST_STAGE) begin
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (!seq_done_o) begin
                        // First DONE edge: announce completion; ack only a warm sequence.
                        seq_done_o <= 1'b1;
                        warm_ack_o <= warm;
                        warm       <= 1'b0;
                    end else if (warm_req_i) begin
                        rst_dom_o  <= ALL_ONES;
                        stage_o    <= '0;
                        seq_done_o <= 1'b0;
                        cnt        <= '0;
                        warm       <= 1'b1;
                        state      <= WARM;
                    end
                end
                WARM: begin
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= SEQ;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= SEQ;
                end
            endcase
        end
    end

    // Domain resets must always be a run of ones from bit stage_o up to the MSB.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            a_contig: assert (rst_dom_o == (ALL_ONES << stage_o));
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: randomized timing of warm requests and
// reset pulses, checked against a timeline model of the release schedule.
module tb_rst_seq;

    localparam int N        = 3;
    localparam int GAP      = 4;
    localparam int WARM     = 8;
    localparam int SW       = $clog2(N + 1);
    localparam int SEQ_LEN  = GAP * N + 1;          // edge offset where seq_done rises
    localparam int PERIOD   = WARM + GAP * N + 2;   // warm restart period with req held
    localparam int OW       = N + SW + 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          warm_req = 1'b0;
    logic          warm_ack;
    logic [N-1:0]  rst_dom;
    logic [SW-1:0] stage;
    logic          seq_done;
    logic [OW-1:0] obs;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .NUM_DOMAINS      (N),
        .GAP_CYCLES       (GAP),
        .WARM_HOLD_CYCLES (WARM)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .warm_req_i (warm_req),
        .warm_ack_o (warm_ack),
        .rst_dom_o  (rst_dom),
        .stage_o    (stage),
        .seq_done_o (seq_done)
    );

    assign obs = {rst_dom, stage, seq_done, warm_ack};

    // Expected outputs 'offset' edges after a sequence's virtual zero edge:
    // domain k is released at offset GAP*(k+1); done from GAP*N+1; ack only
    // on that first done edge, and only for a warm sequence.
    function automatic logic [OW-1:0] model(input int offset, input bit warm);
        int            rel;
        logic [N-1:0]  dom;
        logic [SW-1:0] stg;
        logic          done;
        logic          ack;
        rel = (offset <= 0) ? 0 : offset / GAP;
        if (rel > N) rel = N;
        for (int k = 0; k < N; k++) dom[k] = (k >= rel);
        stg  = rel[SW-1:0];
        done = (offset >= SEQ_LEN);
        ack  = warm && (offset == SEQ_LEN);
        return {dom, stg, done, ack};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (rst_dom !== '1) $display("FAIL reset rst_dom: got %b want %b", rst_dom, {N{1'b1}});
        else pass_cnt++;
        total_cnt++;
        if (stage !== '0) $display("FAIL reset stage: got %0d want 0", stage);
        else pass_cnt++;
        total_cnt++;
        if (seq_done !== 1'b0) $display("FAIL reset seq_done: got %b want 0", seq_done);
        else pass_cnt++;
        total_cnt++;
        if (warm_ack !== 1'b0) $display("FAIL reset warm_ack: got %b want 0", warm_ack);
        else pass_cnt++;
    endtask

    // Cold sequence from rst_i; optionally fires a one-cycle warm request mid-SEQ.
    task automatic test_cold(input bit with_req);
        int req_edge;
        logic [OW-1:0] exp;
        req_edge = with_req ? int'($urandom_range(1, GAP * N)) : -1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 1; t <= SEQ_LEN + 2; t++) begin
            warm_req = (t == req_edge);
            @(posedge clk);
            #1;
            exp = model(t, 1'b0);
            total_cnt++;
            if (obs !== exp)
                $display("FAIL cold(req@%0d) t=%0d: got %b want %b", req_edge, t, obs, exp);
            else pass_cnt++;
        end
        warm_req = 1'b0;
    endtask

    // Warm request from DONE after a random idle time; expects one ack.
    task automatic test_warm();
        int idle;
        int acks;
        logic [OW-1:0] exp;
        idle = int'($urandom_range(0, 3));
        for (int i = 0; i < idle; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({seq_done, warm_ack} !== 2'b10)
                $display("FAIL warm idle %0d: got done/ack %b%b want 10", i, seq_done, warm_ack);
            else pass_cnt++;
        end
        warm_req = 1'b1;
        acks = 0;
        for (int j = 0; j <= PERIOD; j++) begin
            @(posedge clk);
            #1;
            warm_req = 1'b0;
            acks += int'(warm_ack);
            exp = model(j - WARM, 1'b1);
            total_cnt++;
            if (obs !== exp) $display("FAIL warm j=%0d: got %b want %b", j, obs, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (acks !== 1) $display("FAIL warm ack count: got %0d want 1", acks);
        else pass_cnt++;
    endtask

    // Async rst_i pulse between edges at a random point mid-sequence.
    task automatic test_async_mid();
        int k;
        logic [OW-1:0] exp;
        k = int'($urandom_range(1, GAP * N - 1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 1; t <= k; t++) begin
            @(posedge clk);
            #1;
            exp = model(t, 1'b0);
            total_cnt++;
            if (obs !== exp) $display("FAIL async pre t=%0d: got %b want %b", t, obs, exp);
            else pass_cnt++;
        end
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== model(0, 1'b0))
            $display("FAIL async immediate (after E%0d): got %b want %b", k, obs, model(0, 1'b0));
        else pass_cnt++;
        #1;
        rst = 1'b0;
        for (int t = 1; t <= SEQ_LEN + 2; t++) begin
            @(posedge clk);
            #1;
            exp = model(t, 1'b0);
            total_cnt++;
            if (obs !== exp) $display("FAIL async restart t=%0d: got %b want %b", t, obs, exp);
            else pass_cnt++;
        end
    endtask

    // rst_i pulse during a warm sequence: the pending ack must be discarded.
    task automatic test_warm_reset();
        int r;
        int acks;
        logic [OW-1:0] exp;
        r = int'($urandom_range(1, WARM + GAP * N));
        warm_req = 1'b1;
        for (int j = 0; j <= r; j++) begin
            @(posedge clk);
            #1;
            warm_req = 1'b0;
            exp = model(j - WARM, 1'b1);
            total_cnt++;
            if (obs !== exp) $display("FAIL warmrst pre j=%0d: got %b want %b", j, obs, exp);
            else pass_cnt++;
        end
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== model(0, 1'b0))
            $display("FAIL warmrst immediate (W+%0d): got %b want %b", r, obs, model(0, 1'b0));
        else pass_cnt++;
        #1;
        rst = 1'b0;
        acks = 0;
        for (int t = 1; t <= SEQ_LEN + 2; t++) begin
            @(posedge clk);
            #1;
            acks += int'(warm_ack);
            exp = model(t, 1'b0);
            total_cnt++;
            if (obs !== exp) $display("FAIL warmrst cold t=%0d: got %b want %b", t, obs, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (acks !== 0) $display("FAIL warmrst ack count: got %0d want 0", acks);
        else pass_cnt++;
    endtask

    // Request held high: the sequence restarts every PERIOD cycles with one ack each.
    task automatic test_held_req();
        int acks;
        logic [OW-1:0] exp;
        warm_req = 1'b1;
        acks = 0;
        for (int j = 0; j < 3 * PERIOD; j++) begin
            @(posedge clk);
            #1;
            if (j == 3 * PERIOD - 1) warm_req = 1'b0;
            acks += int'(warm_ack);
            exp = model((j % PERIOD) - WARM, 1'b1);
            total_cnt++;
            if (obs !== exp) $display("FAIL held j=%0d: got %b want %b", j, obs, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (acks !== 3) $display("FAIL held ack count: got %0d want 3", acks);
        else pass_cnt++;
        @(posedge clk);
        #1;
        exp = model(SEQ_LEN + 1, 1'b1);
        total_cnt++;
        if (obs !== exp) $display("FAIL held release: got %b want %b", obs, exp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold(1'b0);
        test_warm();
        test_cold(1'b1);
        test_async_mid();
        test_warm_reset();
        test_held_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
